// File: rtl/global_buffer.sv
// Single-port scratchpad for weights, activations and layer outputs, one wide word per access.
// Opcodes: 0 NOP, 1 LOAD_WEIGHT, 2 LOAD_ACTIVATION, 3 LOAD_OUTPUT, 4 POINTER_RESET, 5 READ_ACTIVATION.
// Optional macro GLOBAL_BUFFER_PERF_CNT_EN adds wr_count_o / rd_count_o.
module global_buffer #(
    parameter int unsigned dataSize       = 8,
    parameter int unsigned interfaceDepth = 16,
    parameter int unsigned addrWidth      = 32,
    parameter int unsigned bufferDepth    = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         instr_i,
    input  logic                               instr_valid_i,
    input  logic [addrWidth-1:0]               weight_start_addr,
    input  logic [addrWidth-1:0]               activation_start_addr,
    input  logic [dataSize*interfaceDepth-1:0] wr_data,
    input  logic                               wr_en,
    output logic                               ready_o,
    output logic [dataSize*interfaceDepth-1:0] rd_data,
    output logic                               rd_data_valid,
    output logic                               err_o
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
    ,
    output logic [31:0]                        wr_count_o,
    output logic [31:0]                        rd_count_o
`endif
);

    localparam int unsigned W  = dataSize * interfaceDepth;
    localparam int unsigned AW = $clog2(bufferDepth);
    localparam int unsigned P  = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_A,
        ST_LOAD_O
    } state_e;

    localparam logic [3:0] I_NOP             = 4'd0;
    localparam logic [3:0] I_LOAD_WEIGHT     = 4'd1;
    localparam logic [3:0] I_LOAD_ACTIVATION = 4'd2;
    localparam logic [3:0] I_LOAD_OUTPUT     = 4'd3;
    localparam logic [3:0] I_POINTER_RESET   = 4'd4;
    localparam logic [3:0] I_READ_ACTIVATION = 4'd5;

    state_e          state_q, state_d;
    logic [P-1:0]    wptr_q, wptr_d;
    logic [P-1:0]    aptr_q, aptr_d;
    logic [P-1:0]    optr_q, optr_d;
    logic [P-1:0]    rptr_q, rptr_d;
    logic [W-1:0]    rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            err_q, err_d;
    logic [P-1:0]    sel_ptr;
    logic            wr_fire;
    logic            start_oob;

    logic [W-1:0]    mem [bufferDepth];

`ifdef GLOBAL_BUFFER_PERF_CNT_EN
    logic [31:0]     wr_cnt_q, wr_cnt_d;
    logic [31:0]     rd_cnt_q, rd_cnt_d;
`endif

    // Next-state: the write uses pre-edge state/pointers, the opcode is applied on top of it.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        aptr_d     = aptr_q;
        optr_d     = optr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        sel_ptr    = '0;
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
`endif

        case (state_q)
            ST_LOAD_W: sel_ptr = wptr_q;
            ST_LOAD_A: sel_ptr = aptr_q;
            ST_LOAD_O: sel_ptr = optr_q;
            default:   sel_ptr = '0;
        endcase

        ready_o   = (state_q != ST_IDLE) && (sel_ptr < P'(bufferDepth));
        wr_fire   = wr_en && ready_o;
        start_oob = (weight_start_addr >= addrWidth'(bufferDepth))
                 || (activation_start_addr >= addrWidth'(bufferDepth));

        if (wr_fire) begin
            case (state_q)
                ST_LOAD_W: wptr_d = wptr_q + P'(1);
                ST_LOAD_A: aptr_d = aptr_q + P'(1);
                ST_LOAD_O: optr_d = optr_q + P'(1);
                default:   ;
            endcase
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
            wr_cnt_d = wr_cnt_q + 32'd1;
`endif
        end

        if (instr_valid_i) begin
            case (instr_i)
                I_NOP:             ;
                I_LOAD_WEIGHT:     state_d = ST_LOAD_W;
                I_LOAD_ACTIVATION: state_d = ST_LOAD_A;
                I_LOAD_OUTPUT:     state_d = ST_LOAD_O;
                I_POINTER_RESET: begin
                    wptr_d  = weight_start_addr[P-1:0];
                    aptr_d  = activation_start_addr[P-1:0];
                    optr_d  = activation_start_addr[P-1:0];
                    rptr_d  = activation_start_addr[P-1:0];
                    err_d   = start_oob;
                    state_d = ST_IDLE;
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
`endif
                end
                I_READ_ACTIVATION: begin
                    rd_valid_d = 1'b1;
                    // Old contents are returned even if the same word is written this cycle.
                    if (rptr_q < P'(bufferDepth)) begin
                        rd_data_d = mem[rptr_q[AW-1:0]];
                        rptr_d    = rptr_q + P'(1);
                    end else begin
                        rd_data_d = '0;
                        err_d     = 1'b1;
                    end
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
                    rd_cnt_d = rd_cnt_q + 32'd1;
`endif
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            aptr_q     <= '0;
            optr_q     <= '0;
            rptr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            aptr_q     <= aptr_d;
            optr_q     <= optr_d;
            rptr_q     <= rptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
`endif
        end
    end

    // Storage is never cleared; reset only aborts a write in flight.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[sel_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign err_o         = err_q;

`ifdef GLOBAL_BUFFER_PERF_CNT_EN
    assign wr_count_o = wr_cnt_q;
    assign rd_count_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_global_buffer.sv
// Self-checking bench for global_buffer: directed scenarios plus randomized traffic vs. a transaction model.
module tb_global_buffer;

    localparam int unsigned W     = 128;
    localparam int unsigned DEPTH = 256;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LA   = 4'd2;
    localparam logic [3:0] OP_LO   = 4'd3;
    localparam logic [3:0] OP_PR   = 4'd4;
    localparam logic [3:0] OP_READ = 4'd5;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    instr;
    logic          iv;
    logic [31:0]   wsa, asa;
    logic [W-1:0]  wd;
    logic          we;
    logic          ready_o;
    logic [W-1:0]  rd_data;
    logic          rd_data_valid;
    logic          err_o;
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
    logic [31:0]   wr_count_o, rd_count_o;
`endif

    global_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .instr_i               (instr),
        .instr_valid_i         (iv),
        .weight_start_addr     (wsa),
        .activation_start_addr (asa),
        .wr_data               (wd),
        .wr_en                 (we),
        .ready_o               (ready_o),
        .rd_data               (rd_data),
        .rd_data_valid         (rd_data_valid),
        .err_o                 (err_o)
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
        ,
        .wr_count_o            (wr_count_o),
        .rd_count_o            (rd_count_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: mode plus four integer pointers over a word array.
    int            m_mode;          // 0 idle, 1 weight, 2 activation, 3 output
    int            m_wp, m_ap, m_op, m_rp;
    logic [W-1:0]  m_mem [DEPTH];
    bit            m_known [DEPTH];
    logic [W-1:0]  m_rdd;
    bit            m_rdd_known;
    bit            m_rdv;
    bit            m_err;
    int unsigned   m_wcnt, m_rcnt;

    function automatic int cur_ptr();
        case (m_mode)
            1:       return m_wp;
            2:       return m_ap;
            3:       return m_op;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_ready();
        return (m_mode != 0) && (cur_ptr() < int'(DEPTH));
    endfunction

    task automatic model_step();
        logic [W-1:0] old_d;
        bit           old_k;
        int           p;
        if (rst) begin
            m_mode = 0; m_wp = 0; m_ap = 0; m_op = 0; m_rp = 0;
            m_rdd = '0; m_rdd_known = 1'b1; m_rdv = 1'b0; m_err = 1'b0;
            m_wcnt = 0; m_rcnt = 0;
            return;
        end
        old_d = '0;
        old_k = 1'b1;
        if (m_rp < int'(DEPTH)) begin
            old_d = m_mem[m_rp];
            old_k = m_known[m_rp];
        end
        m_rdv = 1'b0;
        if (we && m_ready()) begin
            p = cur_ptr();
            m_mem[p] = wd;
            m_known[p] = 1'b1;
            m_wcnt++;
            if (m_mode == 1) m_wp++;
            else if (m_mode == 2) m_ap++;
            else m_op++;
        end
        if (iv) begin
            case (instr)
                OP_NOP: ;
                OP_LW:  m_mode = 1;
                OP_LA:  m_mode = 2;
                OP_LO:  m_mode = 3;
                OP_PR: begin
                    m_wp = int'(wsa % 32'd512);
                    m_ap = int'(asa % 32'd512);
                    m_op = m_ap;
                    m_rp = m_ap;
                    m_err = (wsa >= DEPTH) || (asa >= DEPTH);
                    m_mode = 0;
                    m_wcnt = 0;
                    m_rcnt = 0;
                end
                OP_READ: begin
                    m_rdv = 1'b1;
                    m_rcnt++;
                    if (m_rp < int'(DEPTH)) begin
                        m_rdd = old_d;
                        m_rdd_known = old_k;
                        m_rp++;
                    end else begin
                        m_rdd = '0;
                        m_rdd_known = 1'b1;
                        m_err = 1'b1;
                    end
                end
                default: m_err = 1'b1;
            endcase
        end
    endtask

    // Compare process: every falling edge, DUT outputs vs. model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_o", W'(ready_o), W'(m_ready()));
            check("rd_data_valid", W'(rd_data_valid), W'(m_rdv));
            check("err_o", W'(err_o), W'(m_err));
            if (m_rdd_known) check("rd_data", rd_data, m_rdd);
`ifdef GLOBAL_BUFFER_PERF_CNT_EN
            check("wr_count_o", W'(wr_count_o), W'(m_wcnt));
            check("rd_count_o", W'(rd_count_o), W'(m_rcnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic op(input logic [3:0] code);
        instr = code;
        iv = 1'b1;
        tick();
        iv = 1'b0;
        instr = OP_NOP;
    endtask

    localparam logic [W-1:0] VA  = 128'hAAAA_0001_AAAA_0001_AAAA_0001_AAAA_0001;
    localparam logic [W-1:0] VB  = 128'hBBBB_0002_BBBB_0002_BBBB_0002_BBBB_0002;
    localparam logic [W-1:0] VC  = 128'hCCCC_0003_CCCC_0003_CCCC_0003_CCCC_0003;
    localparam logic [W-1:0] VD  = 128'hDDDD_0004_DDDD_0004_DDDD_0004_DDDD_0004;
    localparam logic [W-1:0] VE  = 128'hEEEE_0005_EEEE_0005_EEEE_0005_EEEE_0005;
    localparam logic [W-1:0] VW1 = 128'h1111_00FE_1111_00FE_1111_00FE_1111_00FE;
    localparam logic [W-1:0] VW2 = 128'h2222_00FF_2222_00FF_2222_00FF_2222_00FF;

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom;
        if (r < 5) return 32'($urandom_range(240, 260));
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [W-1:0] words [3];
        words[0] = VA; words[1] = VB; words[2] = VC;
        for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
        rst = 1'b1; iv = 1'b0; instr = OP_NOP; we = 1'b0;
        wsa = '0; asa = '0; wd = '0;

        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", W'(ready_o), W'(0));
        check("rst_valid", W'(rd_data_valid), W'(0));
        check("rst_err", W'(err_o), W'(0));
        check("rst_rd_data", rd_data, '0);

        // Weights A,B,C at 0x10..0x12, read back by pointing the read pointer there.
        wsa = 32'h10; asa = 32'h40;
        op(OP_PR);
        check("pr_err", W'(err_o), W'(0));
        op(OP_LW);
        for (int i = 0; i < 3; i++) begin
            wd = words[i]; we = 1'b1;
            check("w_ready", W'(ready_o), W'(1));
            tick();
        end
        we = 1'b0;
        wsa = 32'h13; asa = 32'h10;
        op(OP_PR);
        for (int i = 0; i < 3; i++) begin
            op(OP_READ);
            check("w_rd_valid", W'(rd_data_valid), W'(1));
            check("w_rd_data", rd_data, words[i]);
        end
        tick();
        check("rd_valid_drop", W'(rd_data_valid), W'(0));
        check("rd_hold", rd_data, VC);

        // Activation D at 0x40, two reads.
        wsa = 32'h0; asa = 32'h40;
        op(OP_PR);
        op(OP_LA);
        wd = VD; we = 1'b1;
        tick();
        we = 1'b0;
        op(OP_READ);
        check("a_rd_valid", W'(rd_data_valid), W'(1));
        check("a_rd_data", rd_data, VD);
        op(OP_READ);
        check("a_rd2_valid", W'(rd_data_valid), W'(1));
        tick();
        check("a_rd_valid_drop", W'(rd_data_valid), W'(0));

        // Saturation at the top of the buffer.
        asa = 32'd254;
        op(OP_PR);
        op(OP_LA);
        we = 1'b1; wd = VW1;
        check("top_ready0", W'(ready_o), W'(1));
        tick();
        wd = VW2;
        check("top_ready1", W'(ready_o), W'(1));
        tick();
        check("full_ready", W'(ready_o), W'(0));
        wd = VE;
        repeat (4) tick();
        check("stall_ready", W'(ready_o), W'(0));
        check("stall_err", W'(err_o), W'(0));
        we = 1'b0;
        op(OP_READ);
        check("top_rd0", rd_data, VW1);
        op(OP_READ);
        check("top_rd1", rd_data, VW2);
        op(OP_READ);
        check("ovr_data", rd_data, '0);
        check("ovr_valid", W'(rd_data_valid), W'(1));
        check("ovr_err", W'(err_o), W'(1));
        asa = 32'h40;
        op(OP_PR);
        check("pr_clear_err", W'(err_o), W'(0));

        // Output write and read of the same word in one cycle.
        op(OP_LO);
        wd = VE; we = 1'b1; instr = OP_READ; iv = 1'b1;
        tick();
        iv = 1'b0; we = 1'b0; instr = OP_NOP;
        check("rbw_old", rd_data, VD);
        op(OP_PR);
        op(OP_READ);
        check("rbw_new", rd_data, VE);

        // Out-of-range start address.
        asa = 32'd300;
        op(OP_PR);
        check("oob_err", W'(err_o), W'(1));
        asa = 32'h40;
        op(OP_PR);

        // Undefined opcode keeps the load state.
        op(OP_LA);
        op(4'hF);
        check("undef_err", W'(err_o), W'(1));
        check("undef_ready", W'(ready_o), W'(1));

        // Reset in the middle of a write and a read.
        we = 1'b1; wd = VA; instr = OP_READ; iv = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; iv = 1'b0; instr = OP_NOP;
        check("mid_rst_ready", W'(ready_o), W'(0));
        check("mid_rst_valid", W'(rd_data_valid), W'(0));
        check("mid_rst_err", W'(err_o), W'(0));
        op(OP_PR);
        op(OP_READ);
        check("aborted_write", rd_data, VE);

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            iv = ($urandom_range(0, 2) == 0);
            instr = 4'($urandom_range(0, 5));
            if (instr == OP_PR && $urandom_range(0, 2) != 0) instr = OP_READ;
            if ($urandom_range(0, 19) == 0) instr = 4'($urandom_range(6, 15));
            wsa = rand_addr();
            asa = rand_addr();
            we = ($urandom_range(0, 3) != 0);
            wd = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst = 1'b0; iv = 1'b0; we = 1'b0;
        tick();
        tick();
        @(posedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/global_buffer.md
Name: global_buffer

Overview:
- On-chip activation/weight/output scratchpad, one wide word per access.
- Write side consumes the global_buffer_data_itf bufferSide signals; start addresses come from the global_buffer_ctrl_itf controllee signals; opcodes are common::global_buffer_instruction_t.
- Sits between the host/DMA loader and the PE-array feeders.
- Single-port, synchronous-read memory; one instruction and one write accepted per cycle.

Parameters:
- dataSize, 8, bits per element.
- interfaceDepth, 16, elements per word; word width W = interfaceDepth*dataSize.
- addrWidth, 32, width of the start-address inputs.
- bufferDepth, 256, number of words; pointer width P = $clog2(bufferDepth)+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_i  in  4  global_buffer_instruction_t opcode.
- instr_valid_i  in  1  opcode qualifier.
- weight_start_addr  in  addrWidth  weight region base, in words.
- activation_start_addr  in  addrWidth  activation/output region base, in words.
- wr_data  in  W  write word.
- wr_en  in  1  write request.
- ready_o  out  1  write accepted this cycle when wr_en && ready_o.
- rd_data  out  W  read word.
- rd_data_valid  out  1  rd_data qualifier.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, state IDLE, all pointers 0. Memory contents are not cleared. rst mid-operation aborts any write/read in flight; the next cycle is IDLE with rd_data_valid=0.
- Pointers: wptr, aptr, optr, rptr, each P bits.
- FSM states: IDLE, LOAD_W, LOAD_A, LOAD_O. Opcode acts at the edge when instr_valid_i is high; it is ignored otherwise.
  - I_LOAD_WEIGHT -> LOAD_W; I_LOAD_ACTIVATION -> LOAD_A; I_LOAD_OUTPUT -> LOAD_O. These are legal from any state.
  - I_NOP: no change.
  - I_POINTER_RESET: wptr <= weight_start_addr[P-1:0]; aptr, optr, rptr <= activation_start_addr[P-1:0]; err_o cleared; state -> IDLE.
  - I_READ_ACTIVATION: one read of mem[rptr]; rptr++; state unchanged.
  - Undefined opcodes (>5): treated as NOP and set err_o.
- Writes:
  - ready_o = (state != IDLE) && (selected pointer < bufferDepth), combinational from registered state and pointers.
  - Accepted write stores wr_data into mem[ptr] and increments ptr. LOAD_W uses wptr; LOAD_A uses aptr; LOAD_O uses optr (outputs overwrite the activation region for the next layer).
- Reads:
  - Latency 1: rd_data and rd_data_valid are registered the cycle after the opcode.
  - rd_data_valid is high for exactly one cycle per read; rd_data holds its value otherwise.
- Full/overrun: a pointer reaching bufferDepth saturates there and ready_o drops. A read with rptr >= bufferDepth returns rd_data=0 with rd_data_valid=1, sets err_o, and rptr does not increment.
- Start address >= bufferDepth at I_POINTER_RESET: err_o set in that same cycle (not cleared); pointers still loaded truncated.
- Simultaneous events:
  - Write and opcode in the same cycle: the write uses the state and pointer before the edge; the opcode takes effect after.
  - POINTER_RESET with a write: the write lands at the old pointer; the reset value wins over the increment.
  - READ and write to the same address: the read returns old data (read-before-write).

Optional Feature:
- Macro GLOBAL_BUFFER_PERF_CNT_EN.
- Defined: adds outputs wr_count_o[31:0] and rd_count_o[31:0].
  - Count accepted writes and issued reads.
  - Wrap at 2^32.
  - Cleared by rst and by I_POINTER_RESET.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- rst, then weight_start=0x10, activation_start=0x40, POINTER_RESET, LOAD_WEIGHT, write 3 words A,B,C -> each accepted on ready_o=1; mem[0x10..0x12]=A,B,C; wptr=0x13.
- LOAD_ACTIVATION, write D at 0x40, then READ_ACTIVATION x2 -> rd_data=D with valid one cycle later, then a second valid beat; rptr=0x42.
- activation_start=254, POINTER_RESET, LOAD_ACTIVATION, write 3 words -> first two accepted; ready_o=0 after the 2nd; third stalls indefinitely; err_o stays 0.
- READ_ACTIVATION with rptr=256 -> rd_data=0, rd_data_valid=1, err_o=1; POINTER_RESET -> err_o=0.
- LOAD_OUTPUT write E to 0x40 in the same cycle as READ_ACTIVATION at 0x40 -> read returns D; a second read after POINTER_RESET returns E.
- Opcode 4'hF -> no state change, err_o=1; rst asserted mid-write -> ready_o=0, rd_data_valid=0 next cycle.
